// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch front end feeding the IF/ID register.
// Generates the PC sequence and drives a single-outstanding request/response
// instruction-memory port. Redirects flush any in-flight fetch. A NOP bubble
// is presented whenever no valid instruction is available.
// Optional feature: define FETCH_MISALIGN_CHECK_EN to fault misaligned
// redirect targets without a memory access. In the default build the low
// two bits of the target are cleared instead.
module if_fetch_unit #(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [DATA_W-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect,
  input  logic [DATA_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [DATA_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              imem_err,
  output logic [DATA_W-1:0] pc_out,
  output logic [DATA_W-1:0] instr_out,
  output logic [DATA_W-1:0] pcPlus4_out,
  output logic              err_out,
  output logic              valid_out
);

  localparam logic [DATA_W-1:0] WORD_BYTES = DATA_W'(4);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] fetch_pc, fetch_pc_nxt;
  logic              stale, stale_nxt;
  logic [DATA_W-1:0] pc_nxt, instr_nxt, pc4_nxt;
  logic              err_nxt, valid_nxt;
  logic [DATA_W-1:0] target_pc;

`ifdef FETCH_MISALIGN_CHECK_EN
  // Misaligned targets are kept intact so they can be reported as a fault.
  assign target_pc = redirect_pc;
`else
  // Without the check, targets are forced onto a word boundary.
  logic unused_target_lsb;
  assign target_pc         = {redirect_pc[DATA_W-1:2], 2'b00};
  assign unused_target_lsb = ^redirect_pc[1:0];
`endif

  // Memory request decodes from the state register alone.
  assign imem_req  = (state == ST_REQ);
  assign imem_addr = fetch_pc;

  // Next-state and next-output decode; redirect outranks everything.
  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    stale_nxt    = stale;
    pc_nxt       = pc_out;
    instr_nxt    = instr_out;
    pc4_nxt      = pcPlus4_out;
    err_nxt      = err_out;
    valid_nxt    = valid_out;

    if (redirect) begin
      fetch_pc_nxt = target_pc;
      valid_nxt    = 1'b0;
      instr_nxt    = NOP_INSTR;
      err_nxt      = 1'b0;
      case (state)
        ST_REQ: begin
          // The request going out this cycle now targets the old path.
          stale_nxt = 1'b1;
          state_nxt = ST_WAIT;
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            stale_nxt = 1'b0;
            state_nxt = ST_REQ;
          end else begin
            stale_nxt = 1'b1;
          end
        end
        default: begin
          // A late stale response landing here has drained.
          if (imem_rvalid) stale_nxt = 1'b0;
          state_nxt = ST_REQ;
        end
      endcase
`ifdef FETCH_MISALIGN_CHECK_EN
      if (redirect_pc[1:0] != 2'b00) begin
        state_nxt    = ST_HOLD;
        fetch_pc_nxt = redirect_pc + WORD_BYTES;
        pc_nxt       = redirect_pc;
        pc4_nxt      = redirect_pc + WORD_BYTES;
        err_nxt      = 1'b1;
        valid_nxt    = 1'b1;
      end
`endif
    end else begin
      // Any response seen outside WAIT can only be a dropped stale one.
      if (imem_rvalid && (state != ST_WAIT)) stale_nxt = 1'b0;
      case (state)
        ST_BOOT: state_nxt = ST_REQ;
        ST_REQ:  state_nxt = ST_WAIT;
        ST_WAIT: begin
          if (imem_rvalid) begin
            if (stale) begin
              stale_nxt = 1'b0;
              state_nxt = ST_REQ;
            end else begin
              pc_nxt       = fetch_pc;
              instr_nxt    = imem_rdata;
              pc4_nxt      = fetch_pc + WORD_BYTES;
              err_nxt      = imem_err;
              valid_nxt    = 1'b1;
              fetch_pc_nxt = fetch_pc + WORD_BYTES;
              state_nxt    = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            valid_nxt = 1'b0;
            instr_nxt = NOP_INSTR;
            err_nxt   = 1'b0;
            state_nxt = ST_REQ;
          end
        end
        default: state_nxt = ST_BOOT;
      endcase
    end
  end

  // State, fetch pointer and presented IF/ID bundle registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_BOOT;
      fetch_pc    <= RESET_PC;
      stale       <= 1'b0;
      pc_out      <= RESET_PC;
      instr_out   <= NOP_INSTR;
      pcPlus4_out <= RESET_PC + WORD_BYTES;
      err_out     <= 1'b0;
      valid_out   <= 1'b0;
    end else begin
      state       <= state_nxt;
      fetch_pc    <= fetch_pc_nxt;
      stale       <= stale_nxt;
      pc_out      <= pc_nxt;
      instr_out   <= instr_nxt;
      pcPlus4_out <= pc4_nxt;
      err_out     <= err_nxt;
      valid_out   <= valid_nxt;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a variable-latency instruction memory.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] BASE = 32'h0050_0093;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_err = 1'b0;
  logic [31:0] pc_out, instr_out, pcPlus4_out;
  logic        err_out, valid_out;

  int          n_tests = 0;
  int          n_fail = 0;

  // memory model state
  int          lat = 1;
  logic [31:0] err_addr = 32'hFFFF_FFFF;
  bit          pend = 1'b0;
  int          cnt = 0;
  logic [31:0] paddr = 32'h0;

  if_fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .imem_err    (imem_err),
    .pc_out      (pc_out),
    .instr_out   (instr_out),
    .pcPlus4_out (pcPlus4_out),
    .err_out     (err_out),
    .valid_out   (valid_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return BASE + a;
  endfunction

  // Memory: a request seen in cycle c is answered in cycle c+lat.
  always @(negedge clk) begin
    imem_rvalid = 1'b0;
    imem_err    = 1'b0;
    imem_rdata  = 32'h0;
    if (rst) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        cnt = cnt - 1;
        if (cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(paddr);
          imem_err    = (paddr == err_addr);
          pend        = 1'b0;
        end
      end
      if (imem_req) begin
        pend  = 1'b1;
        cnt   = lat;
        paddr = imem_addr;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_req(input string tag, input logic [31:0] exp_addr,
                          output int n, output bit saw_valid);
    n = 0;
    saw_valid = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (valid_out) saw_valid = 1'b1;
    end while (!imem_req && n < 40);
    chk({tag, "_req"}, {31'b0, imem_req}, 32'd1);
    chk({tag, "_addr"}, imem_addr, exp_addr);
  endtask

  task automatic wait_valid(input string tag, input logic [31:0] exp_pc,
                            input logic [31:0] exp_instr, input logic exp_err,
                            output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!valid_out && n < 40);
    chk({tag, "_valid"}, {31'b0, valid_out}, 32'd1);
    chk({tag, "_pc"}, pc_out, exp_pc);
    chk({tag, "_pc4"}, pcPlus4_out, exp_pc + 32'd4);
    chk({tag, "_instr"}, instr_out, exp_instr);
    chk({tag, "_err"}, {31'b0, err_out}, {31'b0, exp_err});
  endtask

  initial begin
    int n;
    bit sv;
    logic [31:0] a;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_pc4", pcPlus4_out, 32'h4);
    chk("rst_instr", instr_out, NOP);
    chk("rst_err", {31'b0, err_out}, 32'd0);
    chk("rst_valid", {31'b0, valid_out}, 32'd0);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    rst = 1'b0;

    // Sequential fetch, L=1
    for (int i = 0; i < 3; i++) begin
      a = 32'(i * 4);
      wait_req("seq", a, n, sv);
      if (i == 0) chk("seq_first_req_delay", n, 32'd1);
      wait_valid("seq", a, mem_word(a), 1'b0, n);
      chk("seq_latency", n, 32'd2);
    end
    @(negedge clk);
    chk("seq_bubble_valid", {31'b0, valid_out}, 32'd0);
    chk("seq_bubble_instr", instr_out, NOP);
    chk("seq_next_addr", imem_addr, 32'hC);

    // Stall holds the presented word
    stall = 1'b1;
    wait_valid("stall", 32'hC, mem_word(32'hC), 1'b0, n);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_valid", {31'b0, valid_out}, 32'd1);
      chk("stall_pc", pc_out, 32'hC);
      chk("stall_instr", instr_out, mem_word(32'hC));
      chk("stall_noreq", {31'b0, imem_req}, 32'd0);
    end
    stall = 1'b0;
    lat   = 3;
    @(negedge clk);
    chk("unstall_req", {31'b0, imem_req}, 32'd1);
    chk("unstall_addr", imem_addr, 32'h10);
    chk("unstall_valid", {31'b0, valid_out}, 32'd0);

    // Redirect during WAIT with the response still pending (L=3)
    @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 32'h100;
    @(negedge clk);
    redirect = 1'b0;
    chk("rdw_valid", {31'b0, valid_out}, 32'd0);
    wait_req("rdw", 32'h100, n, sv);
    chk("rdw_req_delay", n, 32'd2);
    chk("rdw_no_valid", {31'b0, sv}, 32'd0);
    wait_valid("rdw", 32'h100, mem_word(32'h100), 1'b0, n);
    chk("rdw_latency", n, 32'd4);
    lat = 1;

    // Redirect coincident with the response
    wait_req("rdr", 32'h104, n, sv);
    @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 32'h200;
    @(negedge clk);
    redirect = 1'b0;
    chk("rdr_req", {31'b0, imem_req}, 32'd1);
    chk("rdr_addr", imem_addr, 32'h200);
    chk("rdr_valid", {31'b0, valid_out}, 32'd0);
    wait_valid("rdr", 32'h200, mem_word(32'h200), 1'b0, n);

    // Access fault on fetch at 0x20 (redirect from HOLD)
    err_addr = 32'h20;
    redirect = 1'b1;
    redirect_pc = 32'h20;
    @(negedge clk);
    redirect = 1'b0;
    chk("ferr_hold_redirect_valid", {31'b0, valid_out}, 32'd0);
    chk("ferr_req", {31'b0, imem_req}, 32'd1);
    chk("ferr_addr", imem_addr, 32'h20);
    stall = 1'b1;
    wait_valid("ferr", 32'h20, mem_word(32'h20), 1'b1, n);
    @(negedge clk);
    chk("ferr_held_err", {31'b0, err_out}, 32'd1);
    stall = 1'b0;
    @(negedge clk);
    chk("ferr_clr_err", {31'b0, err_out}, 32'd0);
    chk("ferr_clr_valid", {31'b0, valid_out}, 32'd0);
    chk("ferr_clr_instr", instr_out, NOP);
    chk("ferr_next_req", {31'b0, imem_req}, 32'd1);
    chk("ferr_next_addr", imem_addr, 32'h24);

    // Misaligned redirect issued while in REQ
    redirect = 1'b1;
    redirect_pc = 32'h102;
    @(negedge clk);
    redirect = 1'b0;
    chk("mis_noreq", {31'b0, imem_req}, 32'd0);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("mis_valid", {31'b0, valid_out}, 32'd1);
    chk("mis_err", {31'b0, err_out}, 32'd1);
    chk("mis_pc", pc_out, 32'h102);
    chk("mis_pc4", pcPlus4_out, 32'h106);
    chk("mis_instr", instr_out, NOP);
    wait_req("mis", 32'h106, n, sv);
    chk("mis_req_delay", n, 32'd1);
    wait_valid("mis_after", 32'h106, mem_word(32'h106), 1'b0, n);
`else
    chk("mis_valid", {31'b0, valid_out}, 32'd0);
    chk("mis_err", {31'b0, err_out}, 32'd0);
    wait_req("mis", 32'h100, n, sv);
    chk("mis_req_delay", n, 32'd1);
    wait_valid("mis_after", 32'h100, mem_word(32'h100), 1'b0, n);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global guard against a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
